// File: rtl/mem_access_unit.sv
// MA-stage load/store unit: byte-addressed RV32 loads/stores mapped onto a
// word-organised data memory, with word-crossing accesses split over two cycles.
module mem_access_unit #(
    parameter int ADDR_W           = 10,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       address,
    input  logic [31:0]       store_data,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    output logic              dmem_we,
    output logic              dmem_re,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              misalign_fault,
    output logic [15:0]       split_count
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SECOND = 1'b1;

    logic [0:0]        state;
    logic [31:0]       hold;
    logic [1:0]        offset;
    logic [ADDR_W-1:0] word;
    logic [4:0]        sh;
    logic              req, in_second, f3_bad, crossing, fault, legal, start_split;
    logic [3:0]        size_mask;
    logic [7:0]        be_wide;
    logic [63:0]       wdata_wide, rdata_wide;
    logic [31:0]       load_word, load_ext;
    logic              unused_addr;

    assign offset      = address[1:0];
    assign word        = address[ADDR_W+1:2];
    assign sh          = {offset, 3'b000};
    assign unused_addr = ^address[31:ADDR_W+2];
    assign req         = mem_read | mem_write;
    assign in_second   = (state == SECOND);

    // Stores only accept B/H/W; loads additionally accept BU/HU.
    assign f3_bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (mem_write && funct3[2]);

    always_comb begin
        case (funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    assign crossing = ((funct3[1:0] == 2'b01) && (offset == 2'd3)) ||
                      ((funct3[1:0] == 2'b10) && (offset != 2'd0));

    // Inputs are frozen by the stall during SECOND, so they were already vetted.
    assign fault = reset && !in_second && req &&
                   ((mem_read && mem_write) || f3_bad || (crossing && !ALLOW_MISALIGNED));
    assign legal       = reset && req && !fault;
    assign start_split = legal && !in_second && crossing;

    // Low half of each 8-lane/64-bit shift feeds the first word, high half the second.
    assign be_wide    = {4'b0000, size_mask} << offset;
    assign wdata_wide = {32'b0, store_data} << sh;
    assign rdata_wide = in_second ? {dmem_rdata, hold} : {32'b0, dmem_rdata};
    assign load_word  = 32'(rdata_wide >> sh);

    always_comb begin
        case (funct3)
            3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
            3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
            3'b100:  load_ext = {24'b0, load_word[7:0]};
            3'b101:  load_ext = {16'b0, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    assign dmem_addr      = in_second ? word + ADDR_W'(1) : word;
    assign dmem_we        = legal && mem_write;
    assign dmem_re        = legal && mem_read;
    assign dmem_be        = !legal ? 4'b0000 : (in_second ? be_wide[7:4] : be_wide[3:0]);
    assign dmem_wdata     = !(legal && mem_write) ? 32'b0
                          : (in_second ? wdata_wide[63:32] : wdata_wide[31:0]);
    assign load_data      = (legal && mem_read && !start_split) ? load_ext : 32'b0;
    assign stall          = start_split;
    assign misalign_fault = fault;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            hold        <= 32'b0;
            split_count <= 16'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_split) begin
                        state <= SECOND;
                        if (mem_read) hold <= dmem_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                    if (split_count != 16'hFFFF) split_count <= split_count + 16'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-lane memory model and
// hand-computed expected values.
module tb_mem_access_unit;
    logic        clk, reset, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] address, store_data;
    logic [9:0]  dmem_addr, na_addr;
    logic [31:0] dmem_wdata, dmem_rdata, load_data, na_wdata, na_load;
    logic [3:0]  dmem_be, na_be;
    logic        dmem_we, dmem_re, stall, misalign_fault;
    logic        na_we, na_re, na_stall, na_fault;
    logic [15:0] split_count, na_split;
    logic [31:0] mem [0:1023];
    int          checks = 0;
    int          errors = 0;

    mem_access_unit #(.ADDR_W(10), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .address(address), .store_data(store_data),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
        .load_data(load_data), .stall(stall), .misalign_fault(misalign_fault),
        .split_count(split_count));

    mem_access_unit #(.ADDR_W(10), .ALLOW_MISALIGNED(1'b0)) dut_na (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .address(address), .store_data(store_data),
        .dmem_addr(na_addr), .dmem_wdata(na_wdata), .dmem_be(na_be),
        .dmem_we(na_we), .dmem_re(na_re), .dmem_rdata(32'h0),
        .load_data(na_load), .stall(na_stall), .misalign_fault(na_fault),
        .split_count(na_split));

    assign dmem_rdata = mem[dmem_addr];

    always @(posedge clk) begin
        if (dmem_we) begin
            for (int i = 0; i < 4; i++)
                if (dmem_be[i]) mem[dmem_addr][8*i +: 8] <= dmem_wdata[8*i +: 8];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        mem_read = rd; mem_write = wr; funct3 = f3; address = a; store_data = sd;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        @(negedge clk); #1;
        checks++; if ({dmem_we, dmem_re, stall, misalign_fault} !== 4'b0000) begin
            errors++; $display("FAIL rst_strobes got %b exp 0000", {dmem_we, dmem_re, stall, misalign_fault}); end
        checks++; if (load_data !== 32'h0) begin
            errors++; $display("FAIL rst_load got %h exp 0", load_data); end
        checks++; if (split_count !== 16'h0) begin
            errors++; $display("FAIL rst_count got %h exp 0", split_count); end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    endtask

    task automatic test_aligned;
        @(negedge clk); drive(1'b0, 1'b0, 3'b010, 32'h123, 32'hFFFF_FFFF); #1;
        checks++; if ({dmem_we, dmem_re, dmem_be, dmem_wdata, dmem_addr} !== {2'b00, 4'h0, 32'h0, 10'h048}) begin
            errors++; $display("FAIL idle_outputs got be=%b wd=%h addr=%h exp be=0 wd=0 addr=048", dmem_be, dmem_wdata, dmem_addr); end
        @(negedge clk); drive(1'b0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF); #1;
        checks++; if ({dmem_we, dmem_be, dmem_addr, dmem_wdata, stall} !== {1'b1, 4'b1111, 10'h010, 32'hDEADBEEF, 1'b0}) begin
            errors++; $display("FAIL sw_aligned got we=%b be=%b addr=%h wd=%h st=%b", dmem_we, dmem_be, dmem_addr, dmem_wdata, stall); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0); #1;
        checks++; if ({dmem_re, dmem_be, dmem_addr, stall} !== {1'b1, 4'b1111, 10'h010, 1'b0}) begin
            errors++; $display("FAIL lw_aligned_ctl got re=%b be=%b addr=%h st=%b", dmem_re, dmem_be, dmem_addr, stall); end
        checks++; if (load_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_aligned got %h exp deadbeef", load_data); end
    endtask

    task automatic test_extension;
        @(negedge clk); drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h80FF7F01);
        @(negedge clk); drive(1'b1, 1'b0, 3'b000, 32'h43, 32'h0); #1;
        checks++; if (load_data !== 32'hFFFFFF80 || dmem_be !== 4'b1000) begin
            errors++; $display("FAIL lb got %h be=%b exp ffffff80 be=1000", load_data, dmem_be); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b100, 32'h43, 32'h0); #1;
        checks++; if (load_data !== 32'h00000080) begin
            errors++; $display("FAIL lbu got %h exp 00000080", load_data); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b001, 32'h42, 32'h0); #1;
        checks++; if (load_data !== 32'hFFFF80FF || dmem_be !== 4'b1100) begin
            errors++; $display("FAIL lh got %h be=%b exp ffff80ff be=1100", load_data, dmem_be); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b101, 32'h40, 32'h0); #1;
        checks++; if (load_data !== 32'h00007F01) begin
            errors++; $display("FAIL lhu got %h exp 00007f01", load_data); end
        @(negedge clk); drive(1'b0, 1'b1, 3'b000, 32'h41, 32'h000000AB); #1;
        checks++; if (dmem_be !== 4'b0010 || dmem_wdata !== 32'h0000AB00) begin
            errors++; $display("FAIL sb got be=%b wd=%h exp 0010 0000ab00", dmem_be, dmem_wdata); end
        @(negedge clk); drive(1'b0, 1'b1, 3'b001, 32'h42, 32'h00001234); #1;
        checks++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'h12340000) begin
            errors++; $display("FAIL sh got be=%b wd=%h exp 1100 12340000", dmem_be, dmem_wdata); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0); #1;
        checks++; if (load_data !== 32'h1234AB01) begin
            errors++; $display("FAIL sb_sh_readback got %h exp 1234ab01", load_data); end
    endtask

    task automatic test_split_store;
        @(negedge clk); drive(1'b0, 1'b1, 3'b010, 32'h41, 32'h11223344); #1;
        checks++; if ({dmem_we, dmem_addr, dmem_be, dmem_wdata, stall} !== {1'b1, 10'h010, 4'b1110, 32'h22334400, 1'b1}) begin
            errors++; $display("FAIL split_st_c1 got addr=%h be=%b wd=%h st=%b", dmem_addr, dmem_be, dmem_wdata, stall); end
        @(negedge clk); #1;
        checks++; if ({dmem_we, dmem_addr, dmem_be, dmem_wdata, stall} !== {1'b1, 10'h011, 4'b0001, 32'h00000011, 1'b0}) begin
            errors++; $display("FAIL split_st_c2 got addr=%h be=%b wd=%h st=%b", dmem_addr, dmem_be, dmem_wdata, stall); end
        @(negedge clk); drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0); #1;
        checks++; if (split_count !== 16'd1) begin
            errors++; $display("FAIL split_st_count got %0d exp 1", split_count); end
    endtask

    task automatic test_split_load;
        @(negedge clk); drive(1'b0, 1'b1, 3'b010, 32'h40, 32'hAABBCCDD);
        @(negedge clk); drive(1'b0, 1'b1, 3'b010, 32'h44, 32'h11223344);
        @(negedge clk); drive(1'b1, 1'b0, 3'b001, 32'h43, 32'h0); #1;
        checks++; if ({stall, dmem_re, dmem_be, load_data} !== {1'b1, 1'b1, 4'b1000, 32'h0}) begin
            errors++; $display("FAIL split_lh_c1 got st=%b be=%b ld=%h exp st=1 be=1000 ld=0", stall, dmem_be, load_data); end
        @(negedge clk); #1;
        checks++; if ({stall, dmem_addr, dmem_be, load_data} !== {1'b0, 10'h011, 4'b0001, 32'h000044AA}) begin
            errors++; $display("FAIL split_lh_c2 got st=%b addr=%h be=%b ld=%h exp ld=000044aa", stall, dmem_addr, dmem_be, load_data); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h42, 32'h0); #1;
        checks++; if (stall !== 1'b1 || dmem_be !== 4'b1100) begin
            errors++; $display("FAIL split_lw_c1 got st=%b be=%b exp 1 1100", stall, dmem_be); end
        @(negedge clk); #1;
        checks++; if (load_data !== 32'h3344AABB || dmem_be !== 4'b0011) begin
            errors++; $display("FAIL split_lw_c2 got ld=%h be=%b exp 3344aabb 0011", load_data, dmem_be); end
        @(negedge clk); drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0); #1;
        checks++; if (split_count !== 16'd3) begin
            errors++; $display("FAIL split_ld_count got %0d exp 3", split_count); end
    endtask

    task automatic test_wrap;
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'hFFD, 32'h0); #1;
        checks++; if (dmem_addr !== 10'h3FF || stall !== 1'b1) begin
            errors++; $display("FAIL wrap_c1 got addr=%h st=%b exp 3ff 1", dmem_addr, stall); end
        @(negedge clk); #1;
        checks++; if (dmem_addr !== 10'h000 || dmem_re !== 1'b1) begin
            errors++; $display("FAIL wrap_c2 got addr=%h re=%b exp 000 1", dmem_addr, dmem_re); end
    endtask

    task automatic test_fault;
        @(negedge clk); drive(1'b1, 1'b1, 3'b010, 32'h40, 32'h0); #1;
        checks++; if ({misalign_fault, dmem_we, dmem_re, stall, dmem_be} !== {1'b1, 3'b000, 4'b0000}) begin
            errors++; $display("FAIL fault_rdwr got f=%b we=%b re=%b st=%b be=%b", misalign_fault, dmem_we, dmem_re, stall, dmem_be); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b011, 32'h40, 32'h0); #1;
        checks++; if (misalign_fault !== 1'b1 || dmem_re !== 1'b0) begin
            errors++; $display("FAIL fault_f3_load got f=%b re=%b exp 1 0", misalign_fault, dmem_re); end
        @(negedge clk); drive(1'b0, 1'b1, 3'b100, 32'h40, 32'h0); #1;
        checks++; if (misalign_fault !== 1'b1 || dmem_we !== 1'b0) begin
            errors++; $display("FAIL fault_f3_store got f=%b we=%b exp 1 0", misalign_fault, dmem_we); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0); #1;
        checks++; if (misalign_fault !== 1'b0 || stall !== 1'b0 || load_data !== 32'hAABBCCDD) begin
            errors++; $display("FAIL fault_recover got f=%b st=%b ld=%h exp 0 0 aabbccdd", misalign_fault, stall, load_data); end
        checks++; if (na_fault !== 1'b0 || na_re !== 1'b1) begin
            errors++; $display("FAIL na_aligned got f=%b re=%b exp 0 1", na_fault, na_re); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h41, 32'h0); #1;
        checks++; if ({na_fault, na_stall, na_re, na_we} !== 4'b1000) begin
            errors++; $display("FAIL na_split got f=%b st=%b re=%b we=%b exp 1 0 0 0", na_fault, na_stall, na_re, na_we); end
        @(negedge clk); #1;
        checks++; if (na_split !== 16'd0 || na_fault !== 1'b1) begin
            errors++; $display("FAIL na_no_state got cnt=%0d f=%b exp 0 1", na_split, na_fault); end
    endtask

    task automatic test_reset_mid_split;
        @(negedge clk); drive(1'b0, 1'b1, 3'b010, 32'h43, 32'h55667788); #1;
        checks++; if (stall !== 1'b1 || dmem_be !== 4'b1000 || dmem_wdata !== 32'h88000000) begin
            errors++; $display("FAIL rms_c1 got st=%b be=%b wd=%h", stall, dmem_be, dmem_wdata); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if ({dmem_we, stall, misalign_fault} !== 3'b000) begin
            errors++; $display("FAIL rms_c2 got we=%b st=%b f=%b exp 000", dmem_we, stall, misalign_fault); end
        @(negedge clk); reset = 1'b1; drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0); #1;
        checks++; if (split_count !== 16'd0) begin
            errors++; $display("FAIL rms_count got %0d exp 0", split_count); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h44, 32'h0); #1;
        checks++; if (load_data !== 32'h11223344) begin
            errors++; $display("FAIL rms_word_w1 got %h exp 11223344", load_data); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0); #1;
        checks++; if (load_data !== 32'h88BBCCDD) begin
            errors++; $display("FAIL rms_word_w got %h exp 88bbccdd", load_data); end
    endtask

    initial begin
        test_reset;
        test_aligned;
        test_extension;
        test_split_store;
        test_split_load;
        test_wrap;
        test_fault;
        test_reset_mid_split;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MA-stage load/store unit that sits directly upstream of the word-organised data memory.
- Translates byte-addressed RV32 load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-indexed memory accesses with byte enables.
- Sign- or zero-extends load data toward WB.
- Splits accesses that cross a word boundary into two back-to-back word accesses, stalling the pipeline for one cycle.

Parameters:
- ADDR_W, 10, word-index width of data memory (1024 words).
- ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses; 0 = raise fault and suppress the access.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_read  in  1  load request from EX/MEM register.
- mem_write  in  1  store request from EX/MEM register.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- address  in  32  byte address (ALU result).
- store_data  in  32  rs2 value.
- dmem_addr  out  ADDR_W  word index to memory.
- dmem_wdata  out  32  lane-aligned write data.
- dmem_be  out  4  byte enables; bit i = byte lane i (little-endian).
- dmem_we  out  1  write strobe.
- dmem_re  out  1  read strobe.
- dmem_rdata  in  32  word read data; combinational, valid in the same cycle as dmem_addr.
- load_data  out  32  extended load result to WB.
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- misalign_fault  out  1  illegal or disallowed access this cycle.
- split_count  out  16  saturating count of completed split accesses.

Behaviour:
- Offset o = address[1:0]; word w = address[ADDR_W+1:2].
- Crossing condition: H with o=3, or W with o≠0.
- FSM states:
  - IDLE: a request with no crossing completes in one cycle, stall=0.
  - IDLE, crossing request and ALLOW_MISALIGNED=1: access w, stall=1, go to SECOND.
  - SECOND: access (w+1) mod 2^ADDR_W (wraps to 0), stall=0, return to IDLE.
  - Inputs are held stable by the stall for the SECOND cycle.
- Store lanes, first access:
  - dmem_wdata = store_data << 8o.
  - dmem_be = size mask (B 0001, H 0011, W 1111) << o, truncated to 4 bits.
- Store lanes, second access:
  - dmem_wdata = store_data >> 8(4-o).
  - dmem_be = bits of the size mask shifted out above bit 3 (e.g. W o=1 → 1110 then 0001; H o=3 → 1000 then 0001).
- Loads:
  - dmem_re=1 and dmem_be = the access mask.
  - First-word rdata is captured into a 32-bit holding register at the IDLE→SECOND edge.
  - Result = ({rdata_now, hold} or {32'b0, rdata}) >> 8o, truncated to size.
  - B/H sign-extended; BU/HU zero-extended; W unchanged.
- load_data is 0 whenever no load completes this cycle, including the IDLE half of a split.
- Faults: misalign_fault=1 combinationally, with no strobes, stall=0, and no state change, for:
  - mem_read and mem_write both high;
  - invalid funct3 (011, 110, 111, or 1xx on a store);
  - crossing request with ALLOW_MISALIGNED=0.
- No request: dmem_we=dmem_re=0, dmem_be=0, dmem_addr=w, dmem_wdata=0.
- split_count increments by 1 on the SECOND→IDLE transition and saturates at 16'hFFFF.
- Reset (reset=0 at a clock edge):
  - state=IDLE, hold=0, split_count=0.
  - While reset=0: dmem_we, dmem_re, stall, misalign_fault, load_data are all 0.
  - Reset in SECOND abandons the access; the second half is never written.
- No write occurs in any cycle with stall=0 other than a legal completing access.

Test Plan:
- Aligned: SW 0xDEADBEEF @0x40, then LW @0x40 → be=1111, dmem_addr=0x10, load_data=0xDEADBEEF, stall never 1.
- Byte/half extension: mem[0x10]=0x80FF7F01.
  - LB @0x43 → 0xFFFFFF80; LBU @0x43 → 0x00000080.
  - LH @0x42 → 0xFFFF80FF; LHU @0x40 → 0x00007F01.
- Split store: SW 0x11223344 @0x41.
  - Cycle 1: addr 0x10, be=1110, wdata=0x22334400, stall=1.
  - Cycle 2: addr 0x11, be=0001, wdata=0x00000011, stall=0.
  - split_count=1.
- Split load: mem[0x10]=0xAABBCCDD, mem[0x11]=0x11223344, LH @0x43 → cycle 1 stall=1, cycle 2 load_data=0x000044AA. LW @0x42 → 0x3344AABB.
- Wrap and fault:
  - LW @0xFFD with ADDR_W=10 → second access dmem_addr=0.
  - mem_read=mem_write=1 → misalign_fault=1, no strobes.
  - ALLOW_MISALIGNED=0, LW @0x41 → fault, no stall.
- Reset mid-split: SW @0x43, assert reset=0 during SECOND → no write to word w+1, stall=0, split_count=0 after reset.
